regfile: RTL and testbench
==========================

# regfile

32-entry × 64-bit register file for the single-cycle datapath: one write port and two asynchronous read ports. Each entry is one 64-bit enabled register (dff array with a per-bit enable mux). A 5:32 write decoder gated by `RegWrite` drives the entry enables, and two 32:1 read muxes select the outputs. Entry 31 (XZR) is hardwired to zero. The block consumes write-back data from the ALU/memory stage and feeds ALU operands.

## Interface
- `WIDTH`, 64: data width of every entry and port.
- `ADDR_BITS`, 5: register address width; entry count is 2^`ADDR_BITS` = 32.
- `clk` input, 1: single clock; all state updates on rising edge.
- `reset` input, 1: asynchronous, active-high; clears every entry to 0 immediately, independent of `clk`.
- `RegWrite` input, 1: write enable for the write port.
- `WriteRegister` input, 5: destination entry index.
- `WriteData` input, 64: value written on the rising edge when `RegWrite`=1.
- `ReadRegister1` input, 5: read port 1 index.
- `ReadRegister2` input, 5: read port 2 index.
- `ReadData1` output, 64: contents of entry `ReadRegister1`.
- `ReadData2` output, 64: contents of entry `ReadRegister2`.

## Operation
- **Write decode:**
  - Enable of entry i = `RegWrite` AND (`WriteRegister` == i), for i = 0..30.
  - Entry 31 enable is tied 0.
  - Exactly one or zero entries are enabled per cycle.
- **Storage:** 31 live 64-bit registers. A disabled entry recirculates its own value (q → d), so it holds.
- **Entry 31:**
  - No storage; its read-mux input is constant 0.
  - Writes to index 31 are discarded silently, with no side effect on other entries.
- **Read:**
  - Purely combinational 32:1 mux per port, keyed by the port's index.
  - The two ports are independent; both may select the same entry.
- **Reset:**
  - Asserting `reset` forces all entries to 0 asynchronously.
  - While `reset`=1, writes are ignored and both read ports return 0 for every index.
  - Reset asserted mid-cycle, concurrent with a pending write, wins; the entry is 0 after reset.
- **Undefined inputs:** X on `WriteRegister` with `RegWrite`=1 is a bench error and is not required to be benign.

## Timing
- **Write latency:** a write is captured at the rising edge. The new value appears on any port reading that entry after that edge, plus the combinational read delay.
- **Read latency:** combinational, zero cycles. The output follows an index change within one mux-tree delay.
- **Read-during-write, same entry, same cycle (default build):** the port returns the old value until the edge, then the new value.
- **Settling:** the decoder plus mux path must settle within one clock period at the datapath clock. The read path must settle before the next edge.
- **Reset values:** every entry, `ReadData1`, and `ReadData2` are 0 after `reset`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Adds a write-to-read forwarding path on each read port.
  - When `RegWrite`=1, the port's read index equals `WriteRegister`, and `WriteRegister` ≠ 31, that port outputs `WriteData` combinationally in the same cycle.
  - Entry 31 is never bypassed and always reads 0.
- Not defined: no bypass; behaviour is exactly as in Timing above.

## Test plan
- **Reset:**
  - Stimulus: write 0xDEADBEEF_00000001 to X5, then pulse `reset` between clock edges.
  - Required: `ReadData1`(X5)=0 immediately, with no clock edge needed.
- **Write/read all:**
  - Stimulus: write 64'(i×0x0101010101010101) to Xi for i = 0..30, then sweep both ports over 0..31.
  - Required: each port returns the written values; X31 reads 0.
- **XZR:**
  - Stimulus: write 0xFFFFFFFF_FFFFFFFF to X31.
  - Required: `ReadData2`(X31)=0; X0–X30 unchanged.
- **Enable low:**
  - Stimulus: `RegWrite`=0 with `WriteRegister`=7 and `WriteData`=0x1234 across 3 edges.
  - Required: X7 keeps its prior value 0x0707070707070707.
- **Dual port same entry:**
  - Stimulus: `ReadRegister1` = `ReadRegister2` = 12.
  - Required: both outputs = 0x0C0C0C0C0C0C0C0C.
- **Read-during-write:**
  - Stimulus: X3=0xAA, then write 0x55 to X3 while reading X3.
  - Required before the edge: port returns 0xAA in the default build, 0x55 with `REGFILE_BYPASS_EN`.
  - Required after the edge: 0x55 in both builds.

Source files
------------

// File: rtl/regfile.sv
// rtl/regfile.sv - 32 x 64 register file, one write port, two combinational read ports, XZR at index 31
// Optional REGFILE_BYPASS_EN: forwards WriteData to a read port that selects the entry being written.
module regfile #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2
);

  localparam int NUM = 1 << ADDR_BITS;
  localparam int LIVE = NUM - 1;
  localparam logic [ADDR_BITS-1:0] XZR = ADDR_BITS'(NUM - 1);

  // Only entries 0..LIVE-1 have storage; the top index is the zero register.
  logic [WIDTH-1:0] regs [LIVE];
  logic [LIVE-1:0]  wen;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  always_comb begin
    wen = '0;
    for (int i = 0; i < LIVE; i++) begin
      wen[i] = RegWrite && (WriteRegister == ADDR_BITS'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LIVE; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LIVE; i++) begin
        if (wen[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Unmatched indices (i.e. XZR) fall through to the zero default.
  always_comb begin
    rd1 = '0;
    for (int i = 0; i < LIVE; i++) begin
      if (ReadRegister1 == ADDR_BITS'(i)) begin
        rd1 = regs[i];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    for (int i = 0; i < LIVE; i++) begin
      if (ReadRegister2 == ADDR_BITS'(i)) begin
        rd2 = regs[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so both ports read zero.
  logic byp1;
  logic byp2;

  assign byp1 = !reset && RegWrite && (WriteRegister != XZR) && (ReadRegister1 == WriteRegister);
  assign byp2 = !reset && RegWrite && (WriteRegister != XZR) && (ReadRegister2 == WriteRegister);

  assign ReadData1 = byp1 ? WriteData : rd1;
  assign ReadData2 = byp2 ? WriteData : rd2;
`else
  assign ReadData1 = rd1;
  assign ReadData2 = rd2;
`endif

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;

  localparam logic [63:0] STEP = 64'h0101010101010101;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int n_cmp;
  int n_err;

  regfile #(.WIDTH(64), .ADDR_BITS(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    logic [63:0] exp1;
    logic [63:0] exp2;
    logic [63:0] pre_exp;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd30;
    #12;
    check("reset_rd1", ReadData1, 64'h0);
    check("reset_rd2", ReadData2, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset between edges
    ReadRegister1 = 5'd5;
    write_reg(5'd5, 64'hDEADBEEF_00000001);
    check("x5_written", ReadData1, 64'hDEADBEEF_00000001);
    #1 reset = 1'b1;
    #1 check("x5_async_reset", ReadData1, 64'h0);
    #1 reset = 1'b0;

    // Write every live entry, then sweep both ports
    for (int i = 0; i < 31; i++) begin
      write_reg(5'(i), 64'(i) * STEP);
    end
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      exp1 = (i == 31) ? 64'h0 : 64'(i) * STEP;
      exp2 = (i == 0) ? 64'h0 : 64'(31 - i) * STEP;
      #1;
      check($sformatf("sweep_rd1[%0d]", i), ReadData1, exp1);
      check($sformatf("sweep_rd2[%0d]", 31 - i), ReadData2, exp2);
    end

    // Writes to XZR vanish
    ReadRegister2 = 5'd31;
    write_reg(5'd31, 64'hFFFFFFFF_FFFFFFFF);
    check("xzr_rd2", ReadData2, 64'h0);
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      #1 check($sformatf("xzr_keep[%0d]", i), ReadData1, 64'(i) * STEP);
    end

    // RegWrite low across three edges
    @(negedge clk);
    RegWrite = 1'b0;
    WriteRegister = 5'd7;
    WriteData = 64'h1234;
    ReadRegister1 = 5'd7;
    repeat (3) @(posedge clk);
    #1 check("enable_low_x7", ReadData1, 64'h0707070707070707);

    // Both ports on the same entry
    ReadRegister1 = 5'd12;
    ReadRegister2 = 5'd12;
    #1;
    check("dual_rd1", ReadData1, 64'h0C0C0C0C0C0C0C0C);
    check("dual_rd2", ReadData2, 64'h0C0C0C0C0C0C0C0C);

    // Read during write to the same entry
    write_reg(5'd3, 64'hAA);
`ifdef REGFILE_BYPASS_EN
    pre_exp = 64'h55;
`else
    pre_exp = 64'hAA;
`endif
    @(negedge clk);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd3;
    RegWrite = 1'b1;
    WriteRegister = 5'd3;
    WriteData = 64'h55;
    #1;
    check("rdw_pre_rd1", ReadData1, pre_exp);
    check("rdw_pre_rd2", ReadData2, pre_exp);
    @(posedge clk);
    #1;
    check("rdw_post_rd1", ReadData1, 64'h55);
    check("rdw_post_rd2", ReadData2, 64'h55);

    // XZR is never forwarded
    WriteRegister = 5'd31;
    WriteData = 64'hFFFF;
    ReadRegister1 = 5'd31;
    #1 check("xzr_no_bypass", ReadData1, 64'h0);

    // Reset wins over a pending write
    @(negedge clk);
    WriteRegister = 5'd9;
    WriteData = 64'hCAFE;
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd12;
    #1 reset = 1'b1;
    #1;
    check("reset_pending_rd1", ReadData1, 64'h0);
    check("reset_pending_rd2", ReadData2, 64'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    reset = 1'b0;
    #1 check("reset_pending_x9", ReadData1, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
